// File: rtl/fc_pkg.sv
// ============================================================================
// fc_pkg : shared types/constants for the fc_layer / fc_argmax datapath.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fc_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } fc_argmax_state_t;

  typedef logic signed [DATA_W-1:0] fc_data_t;

endpackage

`default_nettype wire

// File: rtl/fc_argmax_cmp.sv
// ============================================================================
// fc_argmax_cmp : combinational running max/index (and runner-up with
// FC_ARGMAX_MARGIN_EN) update for one incoming element.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fc_argmax_cmp #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic                     first,
  input  logic signed [DATA_W-1:0] cur_max,
  input  logic [IDX_W-1:0]         cur_idx,
`ifdef FC_ARGMAX_MARGIN_EN
  input  logic signed [DATA_W-1:0] cur_run,
  output logic signed [DATA_W-1:0] new_run,
`endif
  input  logic signed [DATA_W-1:0] in_val,
  input  logic [IDX_W-1:0]         in_idx,
  output logic signed [DATA_W-1:0] new_max,
  output logic [IDX_W-1:0]         new_idx
);

  always_comb begin
    new_max = cur_max;
    new_idx = cur_idx;
    if (first) begin
      new_max = in_val;
      new_idx = in_idx;
    end else if (in_val > cur_max) begin
      new_max = in_val;
      new_idx = in_idx;
    end
  end

`ifdef FC_ARGMAX_MARGIN_EN
  // Runner-up starts at the most negative value so element 1 always lands correctly.
  always_comb begin
    new_run = cur_run;
    if (first) begin
      new_run = {1'b1, {(DATA_W-1){1'b0}}};
    end else if (in_val > cur_max) begin
      new_run = cur_max;
    end else if ((in_val > cur_run) || (in_val == cur_max)) begin
      new_run = in_val;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/fc_argmax.sv
// ============================================================================
// fc_argmax : reduces each NUM_NEURONS-value stream group to argmax + max,
// presented over valid/ready. Optional macro: FC_ARGMAX_MARGIN_EN (res_margin).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fc_argmax #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = fc_pkg::DATA_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [DATA_W-1:0]              in_data,
  input  logic                                  in_valid,
  input  logic                                  res_ready,
  output logic                                  res_valid,
  output logic [$clog2(NUM_NEURONS)-1:0]        res_idx,
  output logic signed [DATA_W-1:0]              res_max,
`ifdef FC_ARGMAX_MARGIN_EN
  output logic [DATA_W:0]                       res_margin,
`endif
  output logic                                  busy,
  output logic                                  err_drop
);

  import fc_pkg::*;

  localparam int               IDX_W = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_NEURONS - 1);

  fc_argmax_state_t          state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          res_idx_q, res_idx_d;
  logic signed [DATA_W-1:0]  res_max_q, res_max_d;
  logic                      err_drop_q, err_drop_d;

  logic                      handshake;
  logic                      accept;
  logic signed [DATA_W-1:0]  upd_max;
  logic [IDX_W-1:0]          upd_idx;

  assign handshake = (state_q == HOLD) && res_ready;
  // A beat coinciding with the handshake is element 0 of the next vector.
  assign accept    = in_valid && ((state_q == ACC) || handshake);

`ifdef FC_ARGMAX_MARGIN_EN
  logic signed [DATA_W-1:0]  run_q, run_d;
  logic signed [DATA_W-1:0]  upd_run;
  logic [DATA_W:0]           res_margin_q, res_margin_d;
  logic [DATA_W:0]           upd_margin;

  assign upd_margin = {upd_max[DATA_W-1], upd_max} - {upd_run[DATA_W-1], upd_run};
`endif

  fc_argmax_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .first   (cnt_q == '0),
    .cur_max (max_q),
    .cur_idx (idx_q),
`ifdef FC_ARGMAX_MARGIN_EN
    .cur_run (run_q),
    .new_run (upd_run),
`endif
    .in_val  (in_data),
    .in_idx  (cnt_q),
    .new_max (upd_max),
    .new_idx (upd_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    max_d      = max_q;
    idx_d      = idx_q;
    res_idx_d  = res_idx_q;
    res_max_d  = res_max_q;
    err_drop_d = err_drop_q;
`ifdef FC_ARGMAX_MARGIN_EN
    run_d        = run_q;
    res_margin_d = res_margin_q;
`endif
    if (handshake) begin
      state_d = ACC;
    end
    if (in_valid && (state_q == HOLD) && !res_ready) begin
      err_drop_d = 1'b1;
    end
    if (accept) begin
      max_d = upd_max;
      idx_d = upd_idx;
`ifdef FC_ARGMAX_MARGIN_EN
      run_d = upd_run;
`endif
      if (cnt_q == LAST) begin
        cnt_d     = '0;
        state_d   = HOLD;
        res_idx_d = upd_idx;
        res_max_d = upd_max;
`ifdef FC_ARGMAX_MARGIN_EN
        res_margin_d = upd_margin;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      cnt_q      <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      res_idx_q  <= '0;
      res_max_q  <= '0;
      err_drop_q <= 1'b0;
`ifdef FC_ARGMAX_MARGIN_EN
      run_q        <= '0;
      res_margin_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      res_idx_q  <= res_idx_d;
      res_max_q  <= res_max_d;
      err_drop_q <= err_drop_d;
`ifdef FC_ARGMAX_MARGIN_EN
      run_q        <= run_d;
      res_margin_q <= res_margin_d;
`endif
    end
  end

  assign res_valid = (state_q == HOLD);
  assign res_idx   = res_idx_q;
  assign res_max   = res_max_q;
  assign busy      = (cnt_q != '0);
  assign err_drop  = err_drop_q;
`ifdef FC_ARGMAX_MARGIN_EN
  assign res_margin = res_margin_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fc_argmax.sv
// ============================================================================
// tb_fc_argmax : directed, table-driven self-checking bench for fc_argmax.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fc_argmax;

  logic              clk;
  logic              rst;
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              res_ready;
  logic              res_valid;
  logic [3:0]        res_idx;
  logic signed [7:0] res_max;
`ifdef FC_ARGMAX_MARGIN_EN
  logic [8:0]        res_margin;
`endif
  logic              busy;
  logic              err_drop;

  int checks = 0;
  int errors = 0;

  fc_argmax #(.NUM_NEURONS(10), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res_max   (res_max),
`ifdef FC_ARGMAX_MARGIN_EN
    .res_margin(res_margin),
`endif
    .busy      (busy),
    .err_drop  (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v [10];
    int idx;
    int mx;
    int mg;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input int idx, input int mx, input int mg);
    chk({tag, " res_valid"}, int'(res_valid), 1);
    chk({tag, " res_idx"}, int'(res_idx), idx);
    chk({tag, " res_max"}, int'(res_max), mx);
`ifdef FC_ARGMAX_MARGIN_EN
    chk({tag, " res_margin"}, int'(res_margin), mg);
`else
    if (mg < 0) $display("note: negative margin in table for %s", tag);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " res_valid"}, int'(res_valid), 0);
    chk({tag, " res_idx"}, int'(res_idx), 0);
    chk({tag, " res_max"}, int'(res_max), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " err_drop"}, int'(err_drop), 0);
`ifdef FC_ARGMAX_MARGIN_EN
    chk({tag, " res_margin"}, int'(res_margin), 0);
`endif
  endtask

  task automatic send_beats(input int k);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(tbl[k].v[i]);
    end
  endtask

  initial begin
    tbl[0] = '{v: '{5, -3, 20, 7, 0, -128, 19, 1, 2, 3}, idx: 2, mx: 20, mg: 1};
    tbl[1] = '{v: '{-9, -4, -4, -100, -100, -100, -100, -100, -100, -100}, idx: 1, mx: -4, mg: 0};
    tbl[2] = '{v: '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7}, idx: 0, mx: 7, mg: 0};
    tbl[3] = '{v: '{127, -128, -128, -128, -128, -128, -128, -128, -128, -128}, idx: 0, mx: 127, mg: 255};
    tbl[4] = '{v: '{3, 8, -2, 8, 1, 0, -5, 6, 8, 2}, idx: 1, mx: 8, mg: 0};
    tbl[5] = '{v: '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10}, idx: 0, mx: -1, mg: 1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Back-to-back vectors with res_ready high: next element 0 rides the handshake.
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (i == 0 && k > 0) check_res($sformatf("vec%0d", k - 1), tbl[k-1].idx, tbl[k-1].mx, tbl[k-1].mg);
        if (i == 1) chk($sformatf("vec%0d busy", k), int'(busy), 1);
        if (i == 9) chk($sformatf("vec%0d pre-last valid", k), int'(res_valid), 0);
        in_valid = 1'b1;
        in_data  = 8'(tbl[k].v[i]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_res("vec5", tbl[5].idx, tbl[5].mx, tbl[5].mg);
    chk("vec5 busy", int'(busy), 0);
    @(negedge clk);
    chk("post handshake valid", int'(res_valid), 0);
    chk("no drop back-to-back", int'(err_drop), 0);

    // Backpressure with two dropped beats during HOLD.
    res_ready = 1'b0;
    send_beats(0);
    @(negedge clk);
    in_valid = 1'b0;
    check_res("bp", 2, 20, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c < 2);
      in_data  = 8'sd99;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp err_drop", int'(err_drop), 1);
    chk("bp busy", int'(busy), 0);
    check_res("bp stalled", 2, 20, 1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp released valid", int'(res_valid), 0);
    chk("bp err_drop sticky", int'(err_drop), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_drop cleared by rst", int'(err_drop), 0);

    // Same-cycle handshake and in_valid: beat is element 0 of an ascending vector.
    res_ready = 1'b0;
    send_beats(1);
    @(negedge clk);
    check_res("hs hold", 1, -4, 0);
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'sd0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("hs valid dropped", int'(res_valid), 0);
        chk("hs busy", int'(busy), 1);
      end
      in_data = 8'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_res("hs asc", 9, 9, 1);
    chk("hs err_drop", int'(err_drop), 0);

    // Reset mid-vector, then a vector with an in_valid gap.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'sd30;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap busy", int'(busy), 1);
      end
      in_valid = 1'b1;
      in_data  = (i == 9) ? 8'sd50 : 8'sd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_res("midrst vec", 9, 50, 49);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
